sipo_pack: RTL
==============

# sipo_pack

Serial-in/parallel-out packer for the DRAM spectrometer datapath, performing the inverse of the 512-to-256 serializer. It collects RATIO consecutive valid 256-bit beats into one 512-bit word and writes that word into a downstream FIFO. The first beat received lands in the most-significant slice, so a serialized stream reassembles bit-exactly. It sits between the DRAM read-back path and the parallel-word FIFO that feeds readout.

## Interface
- INPUT_SIZE, 256, serial beat width in bits.
- OUTPUT_SIZE, 512, packed word width in bits. Must be an integer multiple (≥2) of INPUT_SIZE.
- clk  in  1  single clock; all state on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable; when low, all state holds and fifo_we is forced to 0.
- i_serial  in  INPUT_SIZE  serial beat data.
- i_valid  in  1  beat qualifier; the beat is accepted when ce & i_valid.
- i_sync  in  1  alignment: forces the beat counter so that the current beat (if any) is beat 0.
- fifo_full  in  1  downstream FIFO full.
- o_parallel  out  OUTPUT_SIZE  packed word; stable while pending.
- fifo_we  out  1  FIFO write strobe.
- overflow  out  1  sticky; set when a completed word is dropped.

## Operation
- RATIO = OUTPUT_SIZE/INPUT_SIZE. CNT_W = $clog2(RATIO).
- Beat counter cnt[CNT_W-1:0] tracks the slice position.
- Accepted beat at index k is written to shadow slice [(RATIO-k)*INPUT_SIZE-1 : (RATIO-k-1)*INPUT_SIZE]. Beat 0 fills the MSB slice.
- cnt increments per accepted beat and wraps RATIO-1→0.
- i_sync & i_valid & ce: beat stored as beat 0, then cnt←1. Any partial word is discarded.
- i_sync & ~i_valid & ce: cnt←0, and the partial word is discarded.
- Completion occurs when the accepted beat has k = RATIO-1. The full word (shadow plus final beat) is copied to o_parallel and pending←1.
- The block has two states: ACC (pending=0) and PEND (pending=1).
  - ACC→PEND on completion.
  - PEND→ACC at an edge where fifo_we=1 and no completion occurs.
  - PEND stays PEND when a completion coincides with the write edge. In that case the new word is loaded and written next.
- fifo_we = pending & ~fifo_full & ce (combinational). The FIFO samples o_parallel at that edge.
- Completion while pending and fifo_we=0:
  - The new word is dropped, and o_parallel keeps the older word.
  - overflow←1.
  - cnt still wraps to 0, so alignment is preserved.
- Accumulation continues unaffected while in PEND (double buffering via the shadow register).

## Timing
- Reset values: cnt=0, shadow=0, o_parallel=0, pending=0, fifo_we=0, overflow=0.
- Latency: when the final beat is sampled at edge t, fifo_we is high in the cycle following t, provided fifo_full=0.
- Back-to-back words: with RATIO≥2, continuous valid produces one fifo_we every RATIO cycles with no drops.
- fifo_full high: fifo_we stays 0 and o_parallel is held. fifo_we rises in the same cycle fifo_full falls.
- ce low: cnt, shadow, pending and overflow all hold. fifo_we=0, so no write or drop can happen.
- rst_n low mid-word: all state clears immediately and the partial word is lost. The first beat after release is beat 0.
- overflow clears only on reset.

## Configuration
- SIPO_DROP_CNT_EN defined:
  - Adds output drop_count[15:0], reset 0.
  - drop_count increments on each dropped word and saturates at 16'hFFFF.
- Not defined: no drop_count port exists; only the sticky overflow is available.

## Structure
- Package sipo_pkg holds:
  - The RATIO and CNT_W derivation functions.
  - The state enum {ACC, PEND}.
  - The DROP_CNT_W = 16 constant.
- Sub-module sipo_beat_ctr (counter with wrap, sync load and completion flag) is natural. Slice storage and the write handshake stay in the top.

## Test plan
- Beats A (256'h…A1) and B (…B2) on consecutive cycles with fifo_full=0 → one cycle later fifo_we=1 and o_parallel={A,B}.
- Continuous valid for 8 beats → exactly 4 fifo_we pulses, 2 cycles apart, with words in order and overflow=0.
- fifo_full=1 before the 2nd beat and held 5 cycles → fifo_we=0 throughout, o_parallel stable, fifo_we=1 on the cycle fifo_full drops.
- fifo_full held through two completions → first word retained and written after release; second word dropped; overflow=1. drop_count=1 with SIPO_DROP_CNT_EN.
- Beat X, then i_sync with beat Y, then beat Z → written word is {Y,Z} and X is discarded.
- rst_n pulsed low after one beat → outputs zero asynchronously. The next two beats P,Q yield {P,Q}.

Source files
------------

// File: rtl/sipo_pkg.sv
// ============================================================================
// Module      : sipo_pkg
// Description : Shared constants, state type and width helpers for sipo_pack.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sipo_pkg;

   localparam int DROP_CNT_W = 16;

   typedef enum logic [0:0] {
      ACC  = 1'b0,
      PEND = 1'b1
   } sipo_state_t;

   function automatic int calc_ratio(input int out_w, input int in_w);
      return out_w / in_w;
   endfunction

   function automatic int calc_cnt_w(input int out_w, input int in_w);
      return $clog2(out_w / in_w);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sipo_beat_ctr.sv
// ============================================================================
// Module      : sipo_beat_ctr
// Description : Beat position counter with wrap, sync realignment and
//               completion flag for the serial-to-parallel packer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sipo_beat_ctr #(
   parameter int RATIO = 2,
   parameter int CNT_W = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_ce,
   input  logic             i_valid,
   input  logic             i_sync,
   output logic [CNT_W-1:0] o_beat_idx,
   output logic             o_complete
);

   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(RATIO - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_accept;

   // A sync beat is always treated as slice 0, whatever the counter holds.
   assign w_accept   = i_ce & i_valid;
   assign o_beat_idx = i_sync ? '0 : r_cnt;
   assign o_complete = w_accept & (o_beat_idx == c_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= (o_beat_idx == c_LAST) ? '0 : o_beat_idx + 1'b1;
      end else if (i_ce && i_sync) begin
         r_cnt <= '0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/sipo_pack.sv
// ============================================================================
// Module      : sipo_pack
// Description : Packs RATIO serial beats (first beat in the MSB slice) into
//               one parallel word and hands it to a downstream FIFO.
//               Optional macro SIPO_DROP_CNT_EN adds a saturating drop_count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sipo_pack
   import sipo_pkg::*;
#(
   parameter int INPUT_SIZE  = 256,
   parameter int OUTPUT_SIZE = 512
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ce,
   input  logic [INPUT_SIZE-1:0]  i_serial,
   input  logic                   i_valid,
   input  logic                   i_sync,
   input  logic                   fifo_full,
   output logic [OUTPUT_SIZE-1:0] o_parallel,
   output logic                   fifo_we,
   output logic                   overflow
`ifdef SIPO_DROP_CNT_EN
   ,
   output logic [DROP_CNT_W-1:0]  drop_count
`endif
);

   localparam int c_RATIO  = calc_ratio(OUTPUT_SIZE, INPUT_SIZE);
   localparam int c_CNT_W  = calc_cnt_w(OUTPUT_SIZE, INPUT_SIZE);
   localparam int c_SHAD_W = OUTPUT_SIZE - INPUT_SIZE;

   // The final beat goes straight into the word, so only upper slices are stored.
   logic [c_SHAD_W-1:0] r_shadow;
   sipo_state_t         r_state;
   logic [c_CNT_W-1:0]  w_beat_idx;
   logic                w_complete;
   logic                w_accept;
   logic                w_pending;
   logic                w_drop;

   sipo_beat_ctr #(
      .RATIO (c_RATIO),
      .CNT_W (c_CNT_W)
   ) u_beat_ctr (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_ce       (ce),
      .i_valid    (i_valid),
      .i_sync     (i_sync),
      .o_beat_idx (w_beat_idx),
      .o_complete (w_complete)
   );

   assign w_accept  = ce & i_valid;
   assign w_pending = (r_state == PEND);
   assign fifo_we   = w_pending & ~fifo_full & ce;
   assign w_drop    = w_complete & w_pending & ~fifo_we;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow <= '0;
      end else if (w_accept) begin
         for (int i = 0; i < c_RATIO - 1; i++) begin
            if (w_beat_idx == c_CNT_W'(c_RATIO - 2 - i)) begin
               r_shadow[i*INPUT_SIZE +: INPUT_SIZE] <= i_serial;
            end
         end
      end
   end

   // A completion coinciding with the write edge reloads and stays pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ACC;
         o_parallel <= '0;
         overflow   <= 1'b0;
      end else if (w_complete) begin
         if (!w_pending || fifo_we) begin
            o_parallel <= {r_shadow, i_serial};
            r_state    <= PEND;
         end else begin
            overflow   <= 1'b1;
         end
      end else if (fifo_we) begin
         r_state <= ACC;
      end
   end

`ifdef SIPO_DROP_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_count <= '0;
      end else if (w_drop && (drop_count != {DROP_CNT_W{1'b1}})) begin
         drop_count <= drop_count + 1'b1;
      end
   end
`else
   logic w_drop_unused;
   assign w_drop_unused = w_drop;
`endif

endmodule

`default_nettype wire
